// File: rtl/serial_negate_pkg.sv
// Shared encodings for the serial negate controller and its bit-serial core.
//   ctrl_state_t : word-level controller states (2'b11 is unused and decodes to IDLE)
//   core_state_t : bit-serial complementer states
package serial_negate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } ctrl_state_t;

    typedef enum logic {
        COPY   = 1'b0,
        INVERT = 1'b1
    } core_state_t;

endpackage

// File: rtl/serial_negate_ctrl_if.sv
// Parallel request/result bundle between a requester and serial_negate_ctrl.
//   start, din             : request side (driven by master)
//   busy, done, dout, ovf  : result side (driven by slave)
interface serial_negate_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic             ovf;

    modport master (
        output start, din,
        input  busy, done, dout, ovf
    );

    modport slave (
        input  start, din,
        output busy, done, dout, ovf
    );
endinterface

// File: rtl/twos_comp_bit_fsm.sv
// Bit-serial two's complementer, LSB first: copies bits up to and including the
// first 1, then inverts every later bit.
//   t_clk : clock            r     : async active-high reset (to COPY)
//   clr   : sync clear to COPY, wins over en
//   en    : consume b_in this cycle
//   b_in  : serial input bit b_out : complemented bit (combinational, Mealy)
module twos_comp_bit_fsm
    import serial_negate_pkg::*;
(
    input  logic t_clk,
    input  logic r,
    input  logic clr,
    input  logic en,
    input  logic b_in,
    output logic b_out
);

    core_state_t state;

    // INVERT is sticky until the next clear
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state <= COPY;
        end else if (clr) begin
            state <= COPY;
        end else if (en && b_in) begin
            state <= INVERT;
        end
    end

    assign b_out = (state == INVERT) ? ~b_in : b_in;

endmodule

// File: rtl/serial_negate_ctrl.sv
// Word-level controller: negates a parallel operand by streaming it LSB first
// through twos_comp_bit_fsm and reassembling the result.
//   t_clk : clock                r   : async active-high reset
//   bus   : slave side of serial_negate_ctrl_if
//           start/din in; busy (SHIFT), done (1-cycle pulse), dout, ovf out
module serial_negate_ctrl
    import serial_negate_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                t_clk,
    input  logic                r,
    serial_negate_ctrl_if.slave bus
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ctrl_state_t      state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dout;
    logic             ovf;
    logic             shifting;
    logic             accept;
    logic             b;
    logic             y;

    assign shifting = (state == SHIFT);
    // IDLE, DONE and the unused encoding all accept a new word
    assign accept   = !shifting && bus.start;
    assign b        = sreg[0];
    assign res_next = {y, res[WIDTH-1:1]};

    twos_comp_bit_fsm u_core (
        .t_clk (t_clk),
        .r     (r),
        .clr   (accept),
        .en    (shifting),
        .b_in  (b),
        .b_out (y)
    );

    // Controller FSM, counter, shift registers and result capture
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state <= IDLE;
            sreg  <= '0;
            res   <= '0;
            cnt   <= '0;
            dout  <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    res  <= res_next;
                    sreg <= sreg >> 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        dout  <= res_next;
                        // b=1 with y=1 only happens while still in COPY: the
                        // first 1 is the MSB, i.e. the most negative operand
                        ovf   <= b & y;
                        state <= DONE;
                    end
                end
                default: begin
                    if (bus.start) begin
                        sreg  <= bus.din;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = shifting;
    assign bus.done = (state == DONE);
    assign bus.dout = dout;
    assign bus.ovf  = ovf;

endmodule

// File: tb/tb_serial_negate_ctrl.sv
// Directed bench for serial_negate_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_negate_ctrl;

    logic t_clk = 1'b0;
    logic r;

    always #5 t_clk = ~t_clk;

    serial_negate_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_negate_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_negate_ctrl #(.WIDTH(8)) dut8 (
        .t_clk (t_clk),
        .r     (r),
        .bus   (bus8.slave)
    );

    serial_negate_ctrl #(.WIDTH(4)) dut4 (
        .t_clk (t_clk),
        .r     (r),
        .bus   (bus4.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic s, input logic [7:0] d);
        if (sel) begin
            bus4.start = s;
            bus4.din   = d[3:0];
        end else begin
            bus8.start = s;
            bus8.din   = d;
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? bus4.busy : bus8.busy;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? bus4.done : bus8.done;
    endfunction

    function automatic logic get_ovf(input bit sel);
        return sel ? bus4.ovf : bus8.ovf;
    endfunction

    function automatic logic [7:0] get_dout(input bit sel);
        return sel ? {4'h0, bus4.dout} : bus8.dout;
    endfunction

    // One start pulse; checks busy length, done, result, and that done is one cycle
    task automatic run_op(input bit sel, input logic [7:0] din, input logic [7:0] exp_dout,
                          input logic exp_ovf, input string nm);
        int  w;
        int  busy_cnt;
        bit  seen;
        w        = sel ? 4 : 8;
        busy_cnt = 0;
        seen     = 1'b0;
        @(negedge t_clk);
        drive(sel, 1'b1, din);
        @(negedge t_clk);
        drive(sel, 1'b0, din);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (get_done(sel)) begin
                seen = 1'b1;
                chk({nm, " busy_with_done"}, 32'(get_busy(sel)), 32'd0);
            end else begin
                if (get_busy(sel)) busy_cnt++;
                @(negedge t_clk);
            end
        end
        chk({nm, " done_seen"}, 32'(seen), 32'd1);
        chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(w));
        chk({nm, " dout"}, 32'(get_dout(sel)), 32'(exp_dout));
        chk({nm, " ovf"}, 32'(get_ovf(sel)), 32'(exp_ovf));
        @(negedge t_clk);
        chk({nm, " done_pulse"}, 32'(get_done(sel)), 32'd0);
    endtask

    initial begin
        int dones;
        int t1;
        int t2;
        logic [7:0] d1;
        logic [7:0] d2;
        logic busy_after;

        vecs[0] = '{8'h01, 8'hFF, 1'b0};
        vecs[1] = '{8'h06, 8'hFA, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0};
        vecs[3] = '{8'h7F, 8'h81, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1};
        vecs[5] = '{8'hFF, 8'h01, 1'b0};
        vecs[6] = '{8'h55, 8'hAB, 1'b0};

        r = 1'b1;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (2) @(negedge t_clk);
        chk("rst busy", 32'(bus8.busy), 32'd0);
        chk("rst done", 32'(bus8.done), 32'd0);
        chk("rst dout", 32'(bus8.dout), 32'd0);
        chk("rst ovf",  32'(bus8.ovf),  32'd0);
        chk("rst4 dout", 32'(bus4.dout), 32'd0);
        r = 1'b0;
        @(negedge t_clk);

        for (int i = 0; i < 7; i++) begin
            run_op(1'b0, vecs[i].din, vecs[i].exp_dout, vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // start during SHIFT is ignored
        @(negedge t_clk);
        drive(1'b0, 1'b1, 8'h03);
        @(negedge t_clk);
        drive(1'b0, 1'b0, 8'h03);
        repeat (3) @(negedge t_clk);
        drive(1'b0, 1'b1, 8'h55);
        @(negedge t_clk);
        drive(1'b0, 1'b0, 8'h55);
        dones = 0;
        d1    = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done) begin
                dones++;
                d1 = bus8.dout;
            end
            @(negedge t_clk);
        end
        chk("ign done_count", 32'(dones), 32'd1);
        chk("ign dout", 32'(d1), 32'hFD);

        // async reset mid-SHIFT with non-zero held result
        run_op(1'b0, 8'h80, 8'h80, 1'b1, "pre_rst");
        drive(1'b0, 1'b1, 8'h10);
        @(negedge t_clk);
        drive(1'b0, 1'b0, 8'h10);
        repeat (4) @(negedge t_clk);
        chk("abort busy_before", 32'(bus8.busy), 32'd1);
        #2 r = 1'b1;
        #1;
        chk("abort busy", 32'(bus8.busy), 32'd0);
        chk("abort done", 32'(bus8.done), 32'd0);
        chk("abort dout", 32'(bus8.dout), 32'd0);
        chk("abort ovf",  32'(bus8.ovf),  32'd0);
        @(negedge t_clk);
        r = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge t_clk);
            if (bus8.done) dones++;
        end
        chk("abort no_done", 32'(dones), 32'd0);
        run_op(1'b0, 8'h02, 8'hFE, 1'b0, "post_rst");

        // start held high: back-to-back words, no idle gap
        @(negedge t_clk);
        drive(1'b0, 1'b1, 8'h01);
        @(negedge t_clk);
        drive(1'b0, 1'b1, 8'h02);
        t1 = -1;
        t2 = -1;
        d1 = 8'h00;
        d2 = 8'h00;
        busy_after = 1'b0;
        for (int i = 1; i < 30 && t2 < 0; i++) begin
            if (bus8.done) begin
                if (t1 < 0) begin
                    t1 = i;
                    d1 = bus8.dout;
                end else begin
                    t2 = i;
                    d2 = bus8.dout;
                    drive(1'b0, 1'b0, 8'h02);
                end
            end else if (t1 >= 0 && i == t1 + 1) begin
                busy_after = bus8.busy;
            end
            if (t2 < 0) @(negedge t_clk);
        end
        drive(1'b0, 1'b0, 8'h02);
        chk("b2b first_latency", 32'(t1), 32'd9);
        chk("b2b period", 32'(t2 - t1), 32'd9);
        chk("b2b dout1", 32'(d1), 32'hFF);
        chk("b2b dout2", 32'(d2), 32'hFE);
        chk("b2b no_bubble", 32'(busy_after), 32'd1);
        @(negedge t_clk);
        chk("b2b idle_busy", 32'(bus8.busy), 32'd0);
        chk("b2b idle_done", 32'(bus8.done), 32'd0);

        // WIDTH=4 instance
        run_op(1'b1, 8'h05, 8'h0B, 1'b0, "w4_5");
        run_op(1'b1, 8'h08, 8'h08, 1'b1, "w4_8");
        run_op(1'b1, 8'h01, 8'h0F, 1'b0, "w4_1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
